// File: rtl/alu_pkg.sv
// Shared opcode constants, arbiter state encoding and opcode legality helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOTA = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_LAST = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Opcodes above OP_LAST have no ALU meaning
  function automatic logic op_illegal(input logic [2:0] op);
    return (op > OP_LAST);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first active request at or after ptr, wrapping at N-1.
// Latency: purely combinational.
// Backpressure: none; grant is a pure function of req and ptr.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;

  // Scan offsets 0..N-1 from ptr; the smallest offset with a request wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req[k] && (k == ((int'(ptr) + off) % N))) begin
          gnt[k] = 1'b1;
          idx    = IW'(k);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates NREQ requesters onto one shared external ALU; ALU_ARBITER_OPCHK_EN flags illegal opcodes.
// Latency: accept in cycle N -> rsp_valid in cycle N+2; one operation per 2 cycles back-to-back.
// Backpressure: rsp_ready low holds RESP with stable fields and keeps every req_ready low.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W    = 4,
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  input  logic [NREQ*3-1:0]        req_sel,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  output logic [2:0]               alu_sel,
  input  logic [W-1:0]             alu_out,
  input  logic                     alu_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [W-1:0]             rsp_data,
  output logic                     rsp_carry,
  output logic                     rsp_err
);

  localparam int IW = $clog2(NREQ);

  state_t          state, state_nxt;
  logic            accept;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_gnt;
  logic [W-1:0]    pick_a, pick_b;
  logic [2:0]      pick_sel;
  logic [W-1:0]    lat_a, lat_b;
  logic [2:0]      lat_sel;
  logic [IW-1:0]   lat_id;
`ifdef ALU_ARBITER_OPCHK_EN
  logic            lat_err;
  logic            err_q;
`endif

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  // Select the winner's operand and opcode slices
  always_comb begin
    pick_a   = '0;
    pick_b   = '0;
    pick_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_gnt[k]) begin
        pick_a   = req_a[k*W +: W];
        pick_b   = req_b[k*W +: W];
        pick_sel = req_sel[k*3 +: 3];
      end
    end
  end

  // Next state; accept only from IDLE or from a RESP that is being drained
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (|req_valid) begin
            accept    = 1'b1;
            state_nxt = EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant strobe is masked while reset is held so nothing looks accepted
  assign req_ready = (accept && rst_n) ? win_gnt : '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latch the winner's request and advance the round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_a   <= '0;
      lat_b   <= '0;
      lat_sel <= '0;
      lat_id  <= '0;
      rr_ptr  <= '0;
`ifdef ALU_ARBITER_OPCHK_EN
      lat_err <= 1'b0;
`endif
    end else if (accept) begin
      lat_a  <= pick_a;
      lat_b  <= pick_b;
      lat_id <= win_idx;
      rr_ptr <= (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
`ifdef ALU_ARBITER_OPCHK_EN
      lat_sel <= op_illegal(pick_sel) ? OP_AND : pick_sel;
      lat_err <= op_illegal(pick_sel);
`else
      lat_sel <= pick_sel;
`endif
    end
  end

  // Capture the ALU result during the single EXEC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
    end else if (state == EXEC) begin
`ifdef ALU_ARBITER_OPCHK_EN
      rsp_data  <= lat_err ? '0 : alu_out;
      rsp_carry <= !lat_err && alu_carry;
`else
      rsp_data  <= alu_out;
      rsp_carry <= alu_carry;
`endif
    end
  end

`ifdef ALU_ARBITER_OPCHK_EN
  // Error flag travels with the result it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              err_q <= 1'b0;
    else if (state == EXEC)  err_q <= lat_err;
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign alu_a     = lat_a;
  assign alu_b     = lat_b;
  assign alu_sel   = lat_sel;
  assign rsp_id    = lat_id;
  assign rsp_valid = (state == RESP);

endmodule
